// File: rtl/audio_frontend_ctrl.sv
// Codec init FSM with timeout, button-stepped per-channel power-of-two gain with saturation,
// and a 2-stage valid-gated sample pipeline. Define CLIP_DETECT_EN for sticky per-channel clip flags.
module audio_frontend_ctrl #(
  parameter  int DATA_W          = 16,
  parameter  int CHANNELS        = 2,
  parameter  int VOL_LEVELS      = 4,
  parameter  int INIT_TIMEOUT    = 1000000,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int LVL_W           = (VOL_LEVELS > 1) ? $clog2(VOL_LEVELS) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         init_finish,
  input  logic                         button,
  input  logic [CHANNELS*DATA_W-1:0]   adc_data,
  input  logic                         adc_valid,
  output logic                         init,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  output logic [LVL_W-1:0]             volume_level,
  output logic [1:0]                   fsm_state,
  output logic                         init_error
`ifdef CLIP_DETECT_EN
  ,
  output logic [CHANNELS-1:0]          clip
`endif
);

  localparam int EXT_W = DATA_W + VOL_LEVELS;
  localparam int TO_W  = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(INIT_TIMEOUT - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(VOL_LEVELS - 1);

  localparam logic signed [EXT_W-1:0] SAT_HI = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_LO = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t state;
  logic [TO_W-1:0] to_cnt;

  logic            btn_meta;
  logic            btn_sync;
  logic            btn_stable;
  logic [DB_W-1:0] db_cnt;
  logic            vol_step;

  logic [CHANNELS*DATA_W-1:0] data_p1;
  logic [LVL_W-1:0]           lvl_p1;
  logic                       vld_p1;
  logic                       accept;

  logic signed [EXT_W-1:0]    wide [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] out_next;

  // Sign-extend into the headroom bits first so the shift can never lose the sign.
  function automatic logic signed [EXT_W-1:0] apply_gain(
    input logic signed [DATA_W-1:0] s,
    input logic [LVL_W-1:0]         lvl
  );
    logic signed [EXT_W-1:0] ext;
    ext = {{VOL_LEVELS{s[DATA_W-1]}}, s};
    return ext <<< lvl;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [EXT_W-1:0] v);
    logic signed [EXT_W-1:0] r;
    if (v > SAT_HI)      r = SAT_HI;
    else if (v < SAT_LO) r = SAT_LO;
    else                 r = v;
    return r[DATA_W-1:0];
  endfunction

  assign fsm_state = state;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_HALT;
      init       <= 1'b0;
      init_error <= 1'b0;
      to_cnt     <= '0;
    end else begin
      case (state)
        S_HALT: begin
          state <= S_INIT;
          init  <= 1'b1;
        end
        S_INIT: begin
          if (init_finish) begin
            state <= S_RUN;
          end else if (to_cnt == TO_LAST) begin
            state      <= S_ERROR;
            init       <= 1'b0;
            init_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RUN:   ;
        S_ERROR: ;
        default: state <= S_HALT;
      endcase
    end
  end

  // A step fires on the cycle the debounced level commits a 0->1 transition.
  assign vol_step = btn_sync && !btn_stable && (db_cnt == DB_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      btn_meta     <= 1'b0;
      btn_sync     <= 1'b0;
      btn_stable   <= 1'b0;
      db_cnt       <= '0;
      volume_level <= '0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      if (btn_sync == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        btn_stable <= btn_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (vol_step)
        volume_level <= (volume_level == LVL_LAST) ? '0 : volume_level + 1'b1;
    end
  end

  assign accept = adc_valid && (state == S_RUN);

  always_comb begin
    out_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wide[c] = apply_gain(data_p1[c*DATA_W +: DATA_W], lvl_p1);
      out_next[c*DATA_W +: DATA_W] = saturate(wide[c]);
    end
  end

  // --- stage p1: capture sample and the level in force when it was accepted ---
  // --- stage p2: gain + saturate into the output register ---
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      data_p1   <= '0;
      lvl_p1    <= '0;
      vld_p1    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= adc_data;
        lvl_p1  <= volume_level;
      end
      out_valid <= vld_p1;
      if (vld_p1)
        out_data <= out_next;
    end
  end

`ifdef CLIP_DETECT_EN
  logic [CHANNELS-1:0] sat_flag;

  always_comb begin
    sat_flag = '0;
    for (int c = 0; c < CHANNELS; c++)
      sat_flag[c] = (wide[c] > SAT_HI) || (wide[c] < SAT_LO);
  end

  // A volume step clears the flags even if a saturating sample lands on the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n)
      clip <= '0;
    else if (vol_step)
      clip <= '0;
    else if (vld_p1)
      clip <= clip | sat_flag;
  end
`endif

endmodule
